md_prepend: RTL

Metadata emitter for the packet pipeline: takes an AXI-Stream packet whose metadata rides in `s_axis_tuser` and serializes that metadata in-band as one extra header beat ahead of the packet data. It sits at the egress of the metadata-processing stage, before any link that does not carry `tuser`. It is the counterpart of the ingress stage that recovers metadata into `tuser`. Full-rate forwarding within a packet; one bubble-free header beat per packet.

---
 rtl/md_prepend.sv | 124 ++++++++++++
 1 files changed

// File: rtl/md_prepend.sv
// md_prepend -- metadata emitter.
//
// Serializes the per-packet metadata carried in s_axis_tuser as one in-band
// header beat ahead of the packet data. This lets the packet cross links that
// do not carry tuser. The header beat layout is:
//   tdata[TUSER_W-1:0]         = tuser of the first input beat
//   tdata[TUSER_W+15:TUSER_W]  = MD_MAGIC
//   remaining tdata bits       = 0, tkeep all ones, tlast 0
// Body beats are forwarded unchanged through a single-entry output register.
//
// Ports:
//   clk, aresetn        clock, asynchronous active-low reset
//   s_axis_*            input AXI-Stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   m_axis_*            output AXI-Stream, registered; m_axis_tuser tied to 0
//   pkt_cnt             packets whose header beat was accepted downstream
module md_prepend #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] MD_MAGIC             = 16'hA55A
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_cnt
);

  localparam int DATA_W = C_S_AXIS_DATA_WIDTH;
  localparam int USER_W = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        free;
  logic        load_hdr;
  logic        load_body;
  logic        is_hdr_p0;
  logic [31:0] cnt_q;

  function automatic logic [DATA_W-1:0] build_hdr(input logic [USER_W-1:0] md);
    logic [DATA_W-1:0] h;
    h                   = '0;
    h[USER_W-1:0]       = md;
    h[USER_W+15:USER_W] = MD_MAGIC;
    return h;
  endfunction

  // Output register can take a new beat when empty or draining this cycle.
  assign free = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_axis_tvalid && free) state_d = BODY;
      BODY:    if (s_axis_tvalid && free && s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the first beat is only peeked at (for its tuser); it is consumed
  // later in BODY, so tready never depends on tvalid.
  always_comb begin
    s_axis_tready = 1'b0;
    load_hdr      = 1'b0;
    load_body     = 1'b0;
    case (state_q)
      IDLE: load_hdr = s_axis_tvalid && free;
      BODY: begin
        s_axis_tready = free;
        load_body     = s_axis_tvalid && free;
      end
      default: ;
    endcase
  end

  // ---- output register stage (p0) ----
  // Contents only change when free, so a stalled beat stays stable.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      is_hdr_p0     <= 1'b0;
    end else if (free) begin
      m_axis_tvalid <= load_hdr || load_body;
      if (load_hdr) begin
        m_axis_tdata <= build_hdr(s_axis_tuser);
        m_axis_tkeep <= '1;
        m_axis_tlast <= 1'b0;
        is_hdr_p0    <= 1'b1;
      end else if (load_body) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        is_hdr_p0    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                                      cnt_q <= '0;
    else if (m_axis_tvalid && m_axis_tready && is_hdr_p0) cnt_q <= cnt_q + 32'd1;
  end

  assign pkt_cnt      = cnt_q;
  assign m_axis_tuser = '0;

endmodule
